// File: rtl/nmed_accumulator.sv
// Error-metric accumulator: pairs y/y_exact flow through a 2-stage pipeline into sum/max/mismatch counters.
// Optional max-error tracking is compiled in with `define NMED_MAX_TRACK_EN.
module nmed_accumulator #(
    parameter int unsigned N_SAMPLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y,
    input  logic [31:0] y_exact,
    output logic        busy,
    output logic        done,
    output logic [63:0] sum_abs_err,
    output logic [32:0] max_abs_err,
    output logic [31:0] mismatch_cnt,
    output logic [31:0] sample_cnt
);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RUN  = 2'd1;
    localparam logic [1:0]  S_DONE = 2'd2;
    localparam logic [31:0] N_LIM  = 32'(N_SAMPLES);

    logic [1:0]  state;
    logic [31:0] acc_cnt;
    logic [1:0]  vld_pipe;
    logic [31:0] y_q, ye_q;
    logic [32:0] diff_q;
    logic [32:0] abs_d;
    logic [64:0] sum_ext;
    logic        accept, go, last;

    assign in_ready = (state == S_RUN) && (acc_cnt < N_LIM);
    assign accept   = in_valid && in_ready;
    assign go       = start && (state != S_RUN);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign abs_d    = diff_q[32] ? (33'd0 - diff_q) : diff_q;
    assign sum_ext  = {1'b0, sum_abs_err} + {32'd0, abs_d};
    // Only the final sample can bring the count to N, so the pipeline is empty then.
    assign last     = vld_pipe[1] && (sample_cnt == N_LIM - 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            acc_cnt      <= '0;
            vld_pipe     <= '0;
            y_q          <= '0;
            ye_q         <= '0;
            diff_q       <= '0;
            sum_abs_err  <= '0;
            mismatch_cnt <= '0;
            sample_cnt   <= '0;
        end else if (go) begin
            state        <= S_RUN;
            acc_cnt      <= '0;
            vld_pipe     <= '0;
            sum_abs_err  <= '0;
            mismatch_cnt <= '0;
            sample_cnt   <= '0;
        end else if (state == S_RUN) begin
            vld_pipe <= {vld_pipe[0], accept};
            if (accept) begin
                y_q     <= y;
                ye_q    <= y_exact;
                acc_cnt <= acc_cnt + 32'd1;
            end
            // 33-bit sign-extended subtract cannot overflow
            if (vld_pipe[0])
                diff_q <= {y_q[31], y_q} - {ye_q[31], ye_q};
            if (vld_pipe[1]) begin
                sum_abs_err <= sum_ext[64] ? '1 : sum_ext[63:0];
                if (diff_q != '0)
                    mismatch_cnt <= mismatch_cnt + 32'd1;
                sample_cnt <= sample_cnt + 32'd1;
                if (last)
                    state <= S_DONE;
            end
        end
    end

`ifdef NMED_MAX_TRACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            max_abs_err <= '0;
        else if (go)
            max_abs_err <= '0;
        else if (state == S_RUN && vld_pipe[1] && abs_d > max_abs_err)
            max_abs_err <= abs_d;
    end
`else
    assign max_abs_err = '0;
`endif

endmodule

// File: tb/tb_nmed_accumulator.sv
// Directed bench for nmed_accumulator with N_SAMPLES=4; max-error expectations follow NMED_MAX_TRACK_EN.
module tb_nmed_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] y = '0;
    logic [31:0] y_exact = '0;
    logic        in_ready, busy, done;
    logic [63:0] sum_abs_err;
    logic [32:0] max_abs_err;
    logic [31:0] mismatch_cnt, sample_cnt;

    int tests = 0;
    int fails = 0;

`ifdef NMED_MAX_TRACK_EN
    localparam logic [32:0] EXP_MAX_STD = 33'd20;
    localparam logic [32:0] EXP_MAX_EXT = 33'd4294967295;
`else
    localparam logic [32:0] EXP_MAX_STD = 33'd0;
    localparam logic [32:0] EXP_MAX_EXT = 33'd0;
`endif

    nmed_accumulator #(.N_SAMPLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .y_exact(y_exact), .busy(busy), .done(done), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err), .mismatch_cnt(mismatch_cnt), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // All stimulus changes happen at negedge; tasks enter and leave at a negedge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input int gap);
        int n;
        n = 0;
        in_valid = 1'b1; y = a; y_exact = b;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_pair timeout: in_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    endtask

    task automatic send_std(input int gap);
        send_pair(32'd10, 32'd7, gap);
        send_pair(-32'sd5, -32'sd5, gap);
        send_pair(32'd0, -32'sd3, gap);
        send_pair(32'd100, 32'd120, 0);
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({in_ready, busy, done} !== 3'b000 || sum_abs_err !== 64'd0 || max_abs_err !== 33'd0
            || mismatch_cnt !== 32'd0 || sample_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy/busy/done %b%b%b sum %0d max %0d mis %0d cnt %0d exp all 0",
                     in_ready, busy, done, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({in_ready, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle: rdy/busy/done got %b%b%b exp 000", in_ready, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL b2b_start: busy %b rdy %b exp 1 1", busy, in_ready);
        end
        send_std(0);
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL b2b_ready_low: rdy %b busy %b exp 0 1", in_ready, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_early: done %b exp 0", done); end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || sample_cnt !== 32'd4) begin
            fails++; $display("FAIL b2b_done_timing: done %b cnt %0d exp 1 4", done, sample_cnt);
        end
        tests++;
        if (sum_abs_err !== 64'd26 || max_abs_err !== EXP_MAX_STD || mismatch_cnt !== 32'd3 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_results: sum %0d max %0d mis %0d busy %b exp 26 %0d 3 0",
                     sum_abs_err, max_abs_err, mismatch_cnt, busy, EXP_MAX_STD);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b1 || sum_abs_err !== 64'd26 || sample_cnt !== 32'd4) begin
            fails++; $display("FAIL b2b_hold: done %b sum %0d cnt %0d exp 1 26 4", done, sum_abs_err, sample_cnt);
        end
    endtask

    task automatic test_bubbles();
        int cyc;
        do_start();
        tests++;
        if (sum_abs_err !== 64'd0 || sample_cnt !== 32'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL bub_clear: sum %0d cnt %0d busy %b exp 0 0 1", sum_abs_err, sample_cnt, busy);
        end
        send_std(3);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bub_ready_low: rdy %b exp 0", in_ready); end
        wait_done(cyc);
        tests++;
        if (done !== 1'b1 || sample_cnt !== 32'd4 || sum_abs_err !== 64'd26 || max_abs_err !== EXP_MAX_STD
            || mismatch_cnt !== 32'd3) begin
            fails++;
            $display("FAIL bub_results: done %b cnt %0d sum %0d max %0d mis %0d exp 1 4 26 %0d 3",
                     done, sample_cnt, sum_abs_err, max_abs_err, mismatch_cnt, EXP_MAX_STD);
        end
    endtask

    task automatic test_extremes();
        int cyc;
        do_start();
        send_pair(32'h7FFF_FFFF, 32'h8000_0000, 0);
        send_pair(32'd0, 32'd0, 0);
        send_pair(32'd0, 32'd0, 0);
        send_pair(32'd0, 32'd0, 0);
        wait_done(cyc);
        tests++;
        if (done !== 1'b1 || sum_abs_err !== 64'd4294967295 || max_abs_err !== EXP_MAX_EXT
            || mismatch_cnt !== 32'd1 || sample_cnt !== 32'd4) begin
            fails++;
            $display("FAIL ext_results: done %b sum %0d max %0d mis %0d cnt %0d exp 1 4294967295 %0d 1 4",
                     done, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt, EXP_MAX_EXT);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        do_start();
        send_pair(32'd50, 32'd1, 0);
        send_pair(32'd9, 32'd2, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, busy, done} !== 3'b000 || sum_abs_err !== 64'd0 || max_abs_err !== 33'd0
            || mismatch_cnt !== 32'd0 || sample_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rst_async: rdy/busy/done %b%b%b sum %0d max %0d mis %0d cnt %0d exp all 0",
                     in_ready, busy, done, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({in_ready, busy, done} !== 3'b000 || sample_cnt !== 32'd0 || sum_abs_err !== 64'd0) begin
            fails++;
            $display("FAIL rst_stay_idle: rdy/busy/done %b%b%b cnt %0d sum %0d exp 000 0 0",
                     in_ready, busy, done, sample_cnt, sum_abs_err);
        end
        do_start();
        send_std(0);
        wait_done(cyc);
        tests++;
        if (done !== 1'b1 || sum_abs_err !== 64'd26 || max_abs_err !== EXP_MAX_STD || mismatch_cnt !== 32'd3
            || sample_cnt !== 32'd4) begin
            fails++;
            $display("FAIL rst_rerun: done %b sum %0d max %0d mis %0d cnt %0d exp 1 26 %0d 3 4",
                     done, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt, EXP_MAX_STD);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        do_start();
        send_pair(32'd10, 32'd7, 0);
        send_pair(-32'sd5, -32'sd5, 0);
        do_start();
        send_pair(32'd0, -32'sd3, 1);
        do_start();
        send_pair(32'd100, 32'd120, 0);
        wait_done(cyc);
        tests++;
        if (done !== 1'b1 || sum_abs_err !== 64'd26 || max_abs_err !== EXP_MAX_STD || mismatch_cnt !== 32'd3
            || sample_cnt !== 32'd4) begin
            fails++;
            $display("FAIL start_mid_run: done %b sum %0d max %0d mis %0d cnt %0d exp 1 26 %0d 3 4",
                     done, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt, EXP_MAX_STD);
        end
    endtask

    task automatic test_restart_in_done();
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL restart_pre: done %b exp 1", done); end
        do_start();
        tests++;
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1 || sum_abs_err !== 64'd0 || max_abs_err !== 33'd0
            || mismatch_cnt !== 32'd0 || sample_cnt !== 32'd0) begin
            fails++;
            $display("FAIL restart_clear: busy %b done %b rdy %b sum %0d max %0d mis %0d cnt %0d exp 1 0 1 0 0 0 0",
                     busy, done, in_ready, sum_abs_err, max_abs_err, mismatch_cnt, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bubbles();
        test_extremes();
        test_reset_mid_run();
        test_start_ignored();
        test_restart_in_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nmed_accumulator.md
NMED_ACCUMULATOR -- requirements
Module: nmed_accumulator

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1024, number of sample pairs per run (1 to 2^32-1).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, begin a new run; sampled on rising edge.
REQ-005 SHALL have port in_valid, input, 1, the y/y_exact pair is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a pair this cycle.
REQ-007 SHALL have port y, input, 32, signed approx_sop result.
REQ-008 SHALL have port y_exact, input, 32, signed exact_sop result.
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port done, output, 1, high in DONE.
REQ-011 SHALL have port sum_abs_err, output, 64, unsigned sum of |y - y_exact|.
REQ-012 SHALL have port max_abs_err, output, 33, unsigned largest |y - y_exact|.
REQ-013 SHALL have port mismatch_cnt, output, 32, number of pairs with y != y_exact.
REQ-014 SHALL have port sample_cnt, output, 32, number of pairs accumulated.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE, with the transitions IDLE->RUN on start, RUN->DONE when sample_cnt reaches N_SAMPLES and the pipeline is empty, and DONE->RUN on start.
REQ-016 SHALL ignore start while in RUN.
REQ-017 SHALL clear all result outputs and counters in the same edge that enters RUN.
REQ-018 SHALL drive in_ready = (state==RUN) && (accepted count < N_SAMPLES), accepting a pair only when in_valid && in_ready.
REQ-019 SHALL register diff = sign-extended y minus sign-extended y_exact (33-bit signed, no overflow) one cycle after acceptance.
REQ-020 SHALL update the accumulators with |diff| (33-bit unsigned) two cycles after acceptance.
REQ-021 SHALL pipeline pairs at full throughput of one pair per cycle, and bubbles on in_valid SHALL NOT alter the results.
REQ-022 SHALL saturate sum_abs_err at 2^64-1 rather than wrapping.
REQ-023 SHALL increment mismatch_cnt when diff != 0, and SHALL increment sample_cnt on every accumulation.
REQ-024 SHALL assert done in the cycle after the final accumulation and SHALL hold all outputs stable in DONE until the next start.
REQ-025 SHALL produce sample_cnt == N_SAMPLES exactly when done first asserts.

Reset
REQ-026 SHALL, when rst is asserted, immediately force state IDLE, clear both pipeline stages, and set in_ready, busy, done, sum_abs_err, max_abs_err, mismatch_cnt and sample_cnt to 0, regardless of clk.
REQ-027 SHALL discard in-flight pairs on a reset during RUN, and after rst deasserts SHALL remain in IDLE until start.

Configuration
REQ-028 SHALL compile in max-error tracking when NMED_MAX_TRACK_EN is defined, with max_abs_err = max(max_abs_err, |diff|) on each accumulation.
REQ-029 SHALL tie max_abs_err to constant 0 when NMED_MAX_TRACK_EN is undefined and SHALL remove the compare/register logic, with all other behaviour unchanged.

Verification (N_SAMPLES=4, NMED_MAX_TRACK_EN defined unless stated)
REQ-030 SHALL cover: reset, start, back-to-back pairs (10,7),(-5,-5),(0,-3),(100,120) -> done after the final accumulation, sum_abs_err=26, max_abs_err=20, mismatch_cnt=3, sample_cnt=4.
REQ-031 SHALL cover: the same four pairs with in_valid low for 3 cycles between each pair -> identical results; in_ready low after the 4th acceptance.
REQ-032 SHALL cover: pair (2147483647,-2147483648) then three (0,0) -> max_abs_err=4294967295, sum_abs_err=4294967295, mismatch_cnt=1.
REQ-033 SHALL cover: rst pulsed after 2 accepted pairs -> all outputs 0, state IDLE, no done; a subsequent start plus the four REQ-030 pairs -> REQ-030 results.
REQ-034 SHALL cover: start pulsed mid-RUN -> no effect on the results; start in DONE -> outputs cleared next edge, busy=1.
REQ-035 SHALL cover: NMED_MAX_TRACK_EN undefined with the REQ-030 stimulus -> max_abs_err=0, all other outputs as in REQ-030.
